// File: rtl/hazard_scoreboard.sv
// Load-use and control hazard unit: per-register countdown scoreboard for loads
// of configurable latency, branch/jump flush generation and saturating perf counters.
module hazard_scoreboard #(
    parameter int REGFILE_ADDR_WIDTH = 5,
    parameter int LOAD_LATENCY       = 1,
    parameter int PERF_CNT_WIDTH     = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          IF_Valid,
    input  logic [31:0]                   IF_Instruction,
    input  logic                          ID_Valid,
    input  logic                          ID_Mem_rd_en,
    input  logic [REGFILE_ADDR_WIDTH-1:0] ID_Rd_addr,
    input  logic                          EX_PC_Branch,
    input  logic                          ID_Jump,
    output logic                          Stall,
    output logic                          IF_ID_Flush,
    output logic                          EX_Flush,
    output logic [PERF_CNT_WIDTH-1:0]     Stall_count,
    output logic [PERF_CNT_WIDTH-1:0]     Flush_count
);

    localparam int         NREG   = 2 ** REGFILE_ADDR_WIDTH;
    localparam logic [2:0] RELOAD = 3'(LOAD_LATENCY - 1);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    logic [2:0]                    r_cnt [NREG];
    logic                          r_last_vld;
    logic [REGFILE_ADDR_WIDTH-1:0] r_last_rd;
    logic [PERF_CNT_WIDTH-1:0]     r_stall_count;
    logic [PERF_CNT_WIDTH-1:0]     r_flush_count;

    logic [6:0]                    w_opcode;
    logic [REGFILE_ADDR_WIDTH-1:0] w_rs1;
    logic [REGFILE_ADDR_WIDTH-1:0] w_rs2;
    logic                          w_use_rs1;
    logic                          w_use_rs2;
    logic                          w_issue;
    logic                          w_kill;
    logic                          w_rs1_haz;
    logic                          w_rs2_haz;
    logic                          w_unused_bits;

    function automatic logic [PERF_CNT_WIDTH-1:0] sat_inc(input logic [PERF_CNT_WIDTH-1:0] v);
        return (&v) ? v : v + PERF_CNT_WIDTH'(1);
    endfunction

    assign w_opcode      = IF_Instruction[6:0];
    assign w_rs1         = REGFILE_ADDR_WIDTH'(IF_Instruction[19:15]);
    assign w_rs2         = REGFILE_ADDR_WIDTH'(IF_Instruction[24:20]);
    assign w_unused_bits = ^{IF_Instruction[31:25], IF_Instruction[14:7]};

    always_comb begin
        w_use_rs1 = 1'b0;
        w_use_rs2 = 1'b0;
        case (w_opcode)
            OPC_OP, OPC_BRANCH, OPC_STORE: begin
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
            end
            OPC_OP_IMM, OPC_LOAD, OPC_JALR: w_use_rs1 = 1'b1;
            default: ;
        endcase
    end

    // A load still in ID is not yet in the scoreboard, so it is matched directly.
    assign w_issue   = ID_Valid & ID_Mem_rd_en & (ID_Rd_addr != '0) & ~EX_PC_Branch;
    assign w_kill    = EX_PC_Branch & r_last_vld;
    assign w_rs1_haz = w_use_rs1 & (w_rs1 != '0) &
                       ((r_cnt[w_rs1] != 3'd0) | (w_issue & (ID_Rd_addr == w_rs1)));
    assign w_rs2_haz = w_use_rs2 & (w_rs2 != '0) &
                       ((r_cnt[w_rs2] != 3'd0) | (w_issue & (ID_Rd_addr == w_rs2)));

    assign IF_ID_Flush = EX_PC_Branch | ID_Jump;
    assign EX_Flush    = EX_PC_Branch;
    assign Stall       = IF_Valid & ~IF_ID_Flush & (w_rs1_haz | w_rs2_haz);
    assign Stall_count = r_stall_count;
    assign Flush_count = r_flush_count;

    // Kill of a squashed load in EX takes priority over reload and countdown.
    always_ff @(posedge clk) begin
        for (int r = 0; r < NREG; r++) begin
            if (rst || r == 0) begin
                r_cnt[r] <= 3'd0;
            end else if (w_kill && r_last_rd == REGFILE_ADDR_WIDTH'(r)) begin
                r_cnt[r] <= 3'd0;
            end else if (w_issue && ID_Rd_addr == REGFILE_ADDR_WIDTH'(r)) begin
                r_cnt[r] <= RELOAD;
            end else if (r_cnt[r] != 3'd0) begin
                r_cnt[r] <= r_cnt[r] - 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        r_last_rd <= ID_Rd_addr;
        if (rst) begin
            r_last_vld    <= 1'b0;
            r_stall_count <= '0;
            r_flush_count <= '0;
        end else begin
            r_last_vld <= w_issue;
            if (Stall)       r_stall_count <= sat_inc(r_stall_count);
            if (IF_ID_Flush) r_flush_count <= sat_inc(r_flush_count);
        end
    end

endmodule
